// File: rtl/reg_file_sb_if.sv
// Register-file/scoreboard bus: read ports, write ports, issue strobe and
// scoreboard status, bundled so the core and its driver share one definition.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*DATA_W-1:0] wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic [NREG-1:0]       busy_vec;
    logic                  wr_collide;

    // Issuing/writing side (pipeline control)
    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec, wr_collide
    );

    // Register file itself
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec, wr_collide
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-ported register file with a per-register pending-write scoreboard.
// Reads are zero-latency; optional same-cycle write-to-read forwarding.
// Highest-index write port wins on an address conflict.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [DATA_W-1:0]     regs [NREG];
    logic [NREG-1:0]       busy;
    logic                  wrCollide;
    logic [NREG-1:0]       setVec;
    logic [NREG-1:0]       clrVec;
    logic                  collideNext;
    logic [NRD*DATA_W-1:0] rdDataPk;
    logic [NRD-1:0]        rdBusyPk;

    // Register 0 is inert (never written, never busy) when hardwired to zero.
    function automatic logic isZero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Scoreboard set/clear masks for this cycle.
    always_comb begin
        setVec = '0;
        clrVec = '0;
        if (bus.iss_en && !isZero(bus.iss_addr))
            setVec[bus.iss_addr] = 1'b1;
        for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && !isZero(bus.wr_addr[j*AW +: AW]))
                clrVec[bus.wr_addr[j*AW +: AW]] = 1'b1;
        end
    end

    // Detect two or more enabled write ports aimed at the same live register.
    always_comb begin
        collideNext = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (bus.wr_en[i] && bus.wr_en[j] &&
                    bus.wr_addr[i*AW +: AW] == bus.wr_addr[j*AW +: AW] &&
                    !isZero(bus.wr_addr[i*AW +: AW]))
                    collideNext = 1'b1;
            end
        end
    end

    // State update: later ports overwrite earlier ones, giving top-index
    // priority; a new issue dominates a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy      <= '0;
            wrCollide <= 1'b0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.wr_en[j] && !isZero(bus.wr_addr[j*AW +: AW]))
                    regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*DATA_W +: DATA_W];
            end
            busy      <= (busy & ~clrVec) | setVec;
            wrCollide <= collideNext;
        end
    end

    // Read ports: stored value, optionally overridden by a matching write
    // (a forwarded value is no longer pending); register 0 forced to zero.
    always_comb begin
        logic [AW-1:0] ra;
        ra       = '0;
        rdDataPk = '0;
        rdBusyPk = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = bus.rd_addr[k*AW +: AW];
            rdDataPk[k*DATA_W +: DATA_W] = regs[ra];
            rdBusyPk[k] = busy[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == ra) begin
                        rdDataPk[k*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
                        rdBusyPk[k] = 1'b0;
                    end
                end
            end
            if (isZero(ra)) begin
                rdDataPk[k*DATA_W +: DATA_W] = '0;
                rdBusyPk[k] = 1'b0;
            end
        end
    end

    assign bus.rd_data    = rdDataPk;
    assign bus.rd_busy    = rdBusyPk;
    assign bus.busy_vec   = busy;
    assign bus.wr_collide = wrCollide;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: two instances (forwarding on and off)
// share one stimulus stream; a reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_reg_file_sb;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NRD*AW-1:0] rdAddr;
    logic [NWR-1:0]    wrEn;
    logic [NWR*AW-1:0] wrAddr;
    logic [NWR*DW-1:0] wrData;
    logic              issEn;
    logic [AW-1:0]     issAddr;

    reg_file_sb_if #(.DATA_W(DW), .NREG(NR), .NRD(NRD), .NWR(NWR)) busA ();
    reg_file_sb_if #(.DATA_W(DW), .NREG(NR), .NRD(NRD), .NWR(NWR)) busB ();

    assign busA.rd_addr  = rdAddr;
    assign busA.wr_en    = wrEn;
    assign busA.wr_addr  = wrAddr;
    assign busA.wr_data  = wrData;
    assign busA.iss_en   = issEn;
    assign busA.iss_addr = issAddr;
    assign busB.rd_addr  = rdAddr;
    assign busB.wr_en    = wrEn;
    assign busB.wr_addr  = wrAddr;
    assign busB.wr_data  = wrData;
    assign busB.iss_en   = issEn;
    assign busB.iss_addr = issAddr;

    reg_file_sb #(.DATA_W(DW), .NREG(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1))
        dutA (.clk(clk), .reset(reset), .bus(busA));
    reg_file_sb #(.DATA_W(DW), .NREG(NR), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1))
        dutB (.clk(clk), .reset(reset), .bus(busB));

    // Reference model state
    logic [DW-1:0] mem [NR];
    logic [NR-1:0] mBusy;
    logic          mCol;
    bit            mWe [NWR];
    int            mWa [NWR];
    logic [DW-1:0] mWd [NWR];

    typedef struct {
        logic [NRD*DW-1:0] rdA;
        logic [NRD*DW-1:0] rdB;
        logic [NRD-1:0]    rbA;
        logic [NRD-1:0]    rbB;
        logic [NR-1:0]     bv;
        logic              col;
        int                cyc;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cycNo   = 0;

    function automatic logic [DW-1:0] modelRead(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp)
            for (int j = NWR - 1; j >= 0; j--)
                if (mWe[j] && mWa[j] == a) return mWd[j];
        return mem[a];
    endfunction

    function automatic logic modelBusy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp)
            for (int j = 0; j < NWR; j++)
                if (mWe[j] && mWa[j] == a) return 1'b0;
        return mBusy[a];
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock of stimulus: drive, predict this cycle's outputs, advance model.
    task automatic step(input bit rst, input bit [1:0] we,
                        input int wa0, input logic [DW-1:0] wd0,
                        input int wa1, input logic [DW-1:0] wd1,
                        input bit ie, input int ia, input int ra0, input int ra1);
        exp_t          e;
        int            ra [NRD];
        logic [NR-1:0] nb;
        @(posedge clk);
        #1;
        cycNo++;
        reset   = rst;
        wrEn    = we;
        wrAddr  = {AW'(wa1), AW'(wa0)};
        wrData  = {wd1, wd0};
        issEn   = ie;
        issAddr = AW'(ia);
        rdAddr  = {AW'(ra1), AW'(ra0)};
        mWe[0] = we[0]; mWe[1] = we[1];
        mWa[0] = wa0;   mWa[1] = wa1;
        mWd[0] = wd0;   mWd[1] = wd1;
        ra[0] = ra0;    ra[1] = ra1;
        for (int k = 0; k < NRD; k++) begin
            e.rdA[k*DW +: DW] = modelRead(ra[k], 1'b1);
            e.rdB[k*DW +: DW] = modelRead(ra[k], 1'b0);
            e.rbA[k] = modelBusy(ra[k], 1'b1);
            e.rbB[k] = modelBusy(ra[k], 1'b0);
        end
        e.bv  = mBusy;
        e.col = mCol;
        e.cyc = cycNo;
        q.push_back(e);
        if (rst) begin
            for (int i = 0; i < NR; i++) mem[i] = '0;
            mBusy = '0;
            mCol  = 1'b0;
        end else begin
            nb = mBusy;
            for (int j = 0; j < NWR; j++)
                if (mWe[j] && mWa[j] != 0) begin
                    mem[mWa[j]] = mWd[j];
                    nb[mWa[j]]  = 1'b0;
                end
            if (ie && ia != 0) nb[ia] = 1'b1;
            mBusy = nb;
            mCol  = mWe[0] && mWe[1] && (wa0 == wa1) && (wa0 != 0);
        end
    endtask

    // Monitor: compare the oldest prediction against both instances.
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rd_data_byp",    e.cyc, 64'(busA.rd_data),    64'(e.rdA));
            chk("rd_data_nobyp",  e.cyc, 64'(busB.rd_data),    64'(e.rdB));
            chk("rd_busy_byp",    e.cyc, 64'(busA.rd_busy),    64'(e.rbA));
            chk("rd_busy_nobyp",  e.cyc, 64'(busB.rd_busy),    64'(e.rbB));
            chk("busy_vec_byp",   e.cyc, 64'(busA.busy_vec),   64'(e.bv));
            chk("busy_vec_nobyp", e.cyc, 64'(busB.busy_vec),   64'(e.bv));
            chk("collide_byp",    e.cyc, 64'(busA.wr_collide), 64'(e.col));
            chk("collide_nobyp",  e.cyc, 64'(busB.wr_collide), 64'(e.col));
        end
    end

    function automatic int rndAddr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NR - 1));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        int t;
        reset = 1'b1; wrEn = '0; wrAddr = '0; wrData = '0;
        issEn = 1'b0; issAddr = '0; rdAddr = '0;
        for (int i = 0; i < NR; i++) mem[i] = '0;
        mBusy = '0; mCol = 1'b0;
        repeat (2) @(posedge clk);

        // Reset cycle, then every register on both ports
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int a = 0; a < NR; a += 2)
            step(0, 2'b00, 0, 0, 0, 0, 0, 0, a, a + 1);

        // Forwarding vs registered read of a fresh write
        step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 5);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0);

        // Both ports hit register 7: port 1 wins, collide flag for one cycle
        step(0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 5);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 3);

        // Scoreboard: issue, issue+write, write alone
        step(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 0);
        step(0, 2'b01, 3, 32'h33, 0, 0, 1, 3, 3, 3);
        step(0, 2'b10, 0, 0, 3, 32'h34, 0, 0, 3, 3);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);

        // Write with no pending issue keeps busy clear
        step(0, 2'b01, 6, 32'h66, 0, 0, 0, 0, 6, 6);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 6, 6);

        // Zero register: write and issue are both inert
        step(0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-operation with registers 4 and 9 written and busy
        step(0, 2'b11, 4, 32'h44, 9, 32'h99, 1, 4, 4, 9);
        step(0, 2'b00, 0, 0, 0, 0, 1, 9, 4, 9);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 9);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 4, 9);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 9);

        // Random traffic, biased toward a few registers to provoke conflicts
        repeat (400)
            step(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
                 rndAddr(), $urandom, rndAddr(), $urandom,
                 1'($urandom_range(0, 1)), rndAddr(), rndAddr(), rndAddr());

        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        t = 0;
        while (q.size() > 0 && t < 10) begin
            @(posedge clk);
            t++;
        end
        if (q.size() > 0) begin
            nChecks++;
            nFails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
